scan_display_ctrl: RTL and testbench



---
 rtl/scan_display_ctrl_if.sv | 30 +++
 rtl/scan_display_ctrl.sv | 165 ++++++++++++++++
 tb/tb_scan_display_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/scan_display_ctrl_if.sv
// Port bundle of the display controller: value/control from game logic in, anode/segment drive out.
// Decimal-point signals exist only when SCAN_DISPLAY_DP_EN is defined.
interface scan_display_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14
);
   logic [VALUE_W-1:0]    VALUE;
   logic                  LOAD;
   logic [NUM_DIGITS-1:0] BLINK_MASK;
   logic                  BLINK_TICK;
   logic                  BLANK_LZ;
   logic                  BUSY;
   logic                  OVERFLOW;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;
`ifdef SCAN_DISPLAY_DP_EN
   logic [NUM_DIGITS-1:0] DP_MASK;
   logic                  dp;

   modport master (output VALUE, LOAD, BLINK_MASK, BLINK_TICK, BLANK_LZ, DP_MASK,
                   input  BUSY, OVERFLOW, seg, an, dp);
   modport slave  (input  VALUE, LOAD, BLINK_MASK, BLINK_TICK, BLANK_LZ, DP_MASK,
                   output BUSY, OVERFLOW, seg, an, dp);
`else
   modport master (output VALUE, LOAD, BLINK_MASK, BLINK_TICK, BLANK_LZ,
                   input  BUSY, OVERFLOW, seg, an);
   modport slave  (input  VALUE, LOAD, BLINK_MASK, BLINK_TICK, BLANK_LZ,
                   output BUSY, OVERFLOW, seg, an);
`endif
endinterface

// File: rtl/scan_display_ctrl.sv
// N-digit 7-segment scanner with double-dabble BCD conversion; BUSY for VALUE_W+1 cycles, LOAD while BUSY is dropped.
// an/seg registered one cycle after the scan index; SCAN_DISPLAY_DP_EN adds the decimal-point path.
module scan_display_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 1
) (
   input logic                CLOCK,
   input logic                RESET,
   scan_display_ctrl_if.slave bus
);
   localparam int BCD_W  = NUM_DIGITS * 4;
   localparam int ITER_W = $clog2(VALUE_W + 1);
   localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [63:0] max_disp(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_disp(NUM_DIGITS);

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [VALUE_W-1:0]    bin_q;
   logic [BCD_W-1:0]      bcd_q, bcd_adj, disp_q;
   logic [ITER_W-1:0]     iter_q;
   logic                  ovf_q, ovf_disp_q, phase_q;
   logic [CNT_W-1:0]      ref_cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NUM_DIGITS-1:0] upper_zero, an_d;
   logic [6:0]            seg_d;
   logic [3:0]            nib;
   logic                  dark, zacc;

   always_ff @(posedge CLOCK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.LOAD) state_d = SHIFT;
         SHIFT:   if (iter_q == ITER_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
   end

   // disp_q is only written in DONE, so partial BCD never reaches the display
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
         ovf_disp_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.LOAD) begin
               bin_q  <= bus.VALUE;
               bcd_q  <= '0;
               iter_q <= ITER_W'(VALUE_W);
               ovf_q  <= (64'(bus.VALUE) > MAX_VAL);
            end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
               iter_q         <= iter_q - ITER_W'(1);
            end
            DONE: begin
               disp_q     <= bcd_q;
               ovf_disp_q <= ovf_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.BUSY     = (state_q != IDLE);
   assign bus.OVERFLOW = ovf_disp_q;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ref_cnt_q <= '0;
         idx_q     <= '0;
         phase_q   <= 1'b1;
      end else begin
         phase_q <= phase_q ^ bus.BLINK_TICK;
         if (ref_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            ref_cnt_q <= ref_cnt_q + CNT_W'(1);
         end
      end
   end

   // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero
   always_comb begin
      upper_zero = '0;
      zacc       = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zacc          = zacc & (disp_q[4*i +: 4] == 4'd0);
         upper_zero[i] = zacc;
      end
   end

   always_comb begin
      nib   = disp_q[idx_q*4 +: 4];
      dark  = (bus.BLINK_MASK[idx_q] & ~phase_q) |
              (~ovf_disp_q & bus.BLANK_LZ & (idx_q != '0) & upper_zero[idx_q]);
      seg_d = ovf_disp_q ? 7'b0111111 : seg_code(nib);
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      if (dark) begin
         seg_d = 7'b1111111;
         an_d  = '1;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         bus.an  <= '1;
         bus.seg <= 7'b1111111;
      end else begin
         bus.an  <= an_d;
         bus.seg <= seg_d;
      end
   end

`ifdef SCAN_DISPLAY_DP_EN
   always_ff @(posedge CLOCK) begin
      if (RESET) bus.dp <= 1'b1;
      else       bus.dp <= dark | ~bus.DP_MASK[idx_q];
   end
`endif

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl (4 digits, 14-bit value, 2 cycles per digit).
module tb_scan_display_ctrl;
   localparam int ND = 4;
   localparam int VW = 14;
   localparam int RD = 2;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111, SX = 7'b1111111;

   typedef struct packed {
      logic [VW-1:0]      value;
      logic               blank_lz;
      logic               ovf;
      logic [ND-1:0][6:0] seg;   // seg[i] = digit i; SX means digit dark
   } vec_t;

   logic CLOCK;
   logic RESET;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl [11];
   vec_t exp_q [$];

   scan_display_ctrl_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();

   scan_display_ctrl #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic vec_t mk(input int v, input logic lz, input logic ovf,
                               input logic [6:0] s3, s2, s1, s0);
      vec_t r;
      r.value    = VW'(v);
      r.blank_lz = lz;
      r.ovf      = ovf;
      r.seg      = {s3, s2, s1, s0};
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Observes one full scan (ND*RD cycles); phase-independent per-digit tally.
   task automatic check_display(input vec_t e, input string name);
      int lit_cnt [ND];
      int bad;
      int j;
      bad = 0;
      for (int d = 0; d < ND; d++) lit_cnt[d] = 0;
      chk({name, "_ovf"}, int'(bus.OVERFLOW), int'(e.ovf));
      for (int k = 0; k < ND * RD; k++) begin
         @(negedge CLOCK);
         if (bus.an == '1) begin
            if (bus.seg != SX) bad++;
         end else if ($countones(~bus.an) == 1) begin
            j = 0;
            for (int d = 0; d < ND; d++) if (!bus.an[d]) j = d;
            lit_cnt[j]++;
            if (bus.seg != e.seg[j] || e.seg[j] == SX) bad++;
         end else begin
            bad++;
         end
      end
      for (int d = 0; d < ND; d++)
         chk($sformatf("%s_dig%0d_lit", name, d), lit_cnt[d], (e.seg[d] == SX) ? 0 : RD);
      chk({name, "_bad_samples"}, bad, 0);
   endtask

   task automatic run(input vec_t v, input int second_at, input int second_val, input string name);
      int   busy_len;
      vec_t e;
      bus.BLANK_LZ = v.blank_lz;
      exp_q.push_back(v);
      @(negedge CLOCK);
      bus.VALUE = v.value;
      bus.LOAD  = 1'b1;
      @(negedge CLOCK);
      bus.LOAD = 1'b0;
      busy_len = 0;
      while (bus.BUSY && busy_len < 100) begin
         busy_len++;
         if (second_at != 0 && busy_len == second_at) begin
            bus.VALUE = VW'(second_val);
            bus.LOAD  = 1'b1;
         end else begin
            bus.LOAD = 1'b0;
         end
         @(negedge CLOCK);
      end
      bus.LOAD = 1'b0;
      chk({name, "_busy_len"}, busy_len, VW + 1);
      @(negedge CLOCK);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_scoreboard: got empty queue expected entry", name);
      end else begin
         e = exp_q.pop_front();
         check_display(e, name);
      end
   endtask

   initial begin
      RESET          = 1'b1;
      bus.VALUE      = '0;
      bus.LOAD       = 1'b0;
      bus.BLINK_MASK = '0;
      bus.BLINK_TICK = 1'b0;
      bus.BLANK_LZ   = 1'b0;
`ifdef SCAN_DISPLAY_DP_EN
      bus.DP_MASK    = '0;
`endif

      tbl[0]  = mk(1234,  1'b0, 1'b0, S1, S2, S3, S4);
      tbl[1]  = mk(7,     1'b1, 1'b0, SX, SX, SX, S7);
      tbl[2]  = mk(0,     1'b1, 1'b0, SX, SX, SX, S0);
      tbl[3]  = mk(7,     1'b0, 1'b0, S0, S0, S0, S7);
      tbl[4]  = mk(10000, 1'b0, 1'b1, SD, SD, SD, SD);
      tbl[5]  = mk(9999,  1'b0, 1'b0, S9, S9, S9, S9);
      tbl[6]  = mk(10000, 1'b1, 1'b1, SD, SD, SD, SD);
      tbl[7]  = mk(305,   1'b1, 1'b0, SX, S3, S0, S5);
      tbl[8]  = mk(16383, 1'b1, 1'b1, SD, SD, SD, SD);
      tbl[9]  = mk(1000,  1'b1, 1'b0, S1, S0, S0, S0);
      tbl[10] = mk(86,    1'b0, 1'b0, S0, S0, S8, S6);

      repeat (2) @(negedge CLOCK);
      chk("reset_an",   int'(bus.an), 'hF);
      chk("reset_seg",  int'(bus.seg), int'(SX));
      chk("reset_busy", int'(bus.BUSY), 0);
      chk("reset_ovf",  int'(bus.OVERFLOW), 0);
      RESET = 1'b0;

      for (int i = 0; i < 11; i++) run(tbl[i], 0, 0, $sformatf("vec%0d", i));

      // Blink: two ticks darken then restore the masked digits
      run(mk(1234, 1'b0, 1'b0, S1, S2, S3, S4), 0, 0, "blink_load");
      bus.BLINK_MASK = 4'b0011;
      bus.BLINK_TICK = 1'b1;
      @(negedge CLOCK);
      bus.BLINK_TICK = 1'b0;
      @(negedge CLOCK);
      check_display(mk(1234, 1'b0, 1'b0, S1, S2, SX, SX), "blink_off");
      bus.BLINK_TICK = 1'b1;
      @(negedge CLOCK);
      bus.BLINK_TICK = 1'b0;
      @(negedge CLOCK);
      check_display(mk(1234, 1'b0, 1'b0, S1, S2, S3, S4), "blink_on");
      bus.BLINK_MASK = '0;

      // Second LOAD during conversion must be ignored
      run(mk(42, 1'b0, 1'b0, S0, S0, S4, S2), 5, 99, "ignore_load");

      // Reset mid-conversion aborts and clears the display
      @(negedge CLOCK);
      bus.VALUE = VW'(1234);
      bus.LOAD  = 1'b1;
      @(negedge CLOCK);
      bus.LOAD = 1'b0;
      repeat (4) @(negedge CLOCK);
      chk("midrst_busy_before", int'(bus.BUSY), 1);
      RESET = 1'b1;
      @(negedge CLOCK);
      chk("midrst_busy", int'(bus.BUSY), 0);
      chk("midrst_an",   int'(bus.an), 'hF);
      chk("midrst_seg",  int'(bus.seg), int'(SX));
      RESET = 1'b0;
      repeat (20) @(negedge CLOCK);
      chk("midrst_busy_after", int'(bus.BUSY), 0);
      check_display(mk(0, 1'b0, 1'b0, S0, S0, S0, S0), "midrst_zero");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
